// File: rtl/csi_rx_pkg.sv
// rtl/csi_rx_pkg.sv - shared types and constants for the CSI-2 lane receive path
//
// Purpose: FSM state type and sync constants used by the byte aligner and the
// sync-byte matcher (also intended for the future multi-lane deskew).
// Ports: none (package).
package csi_rx_pkg;

  // Byte aligner states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } align_state_e;

  // SoT leader sequence byte, bit 0 first on the wire.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

  // Number of bit offsets a byte can sit at inside the two-byte window.
  localparam int unsigned SYNC_OFFSETS = 8;

  // Byte starting at bit k of the window {newer, older}.
  function automatic logic [7:0] window_byte(input logic [15:0] w, input logic [2:0] k);
    return w[k +: 8];
  endfunction

endpackage

// File: rtl/csi_rx_sync_match.sv
// rtl/csi_rx_sync_match.sv - combinational sync byte search over a 16-bit window
//
// Purpose: tests the 8 candidate bytes w[k+7:k], k = 0..7, against sync_byte
// and reports the lowest matching offset.
// Ports:
//   w          16-bit window, w[0] earliest bit on the wire
//   sync_byte  byte pattern to search for
//   hit        at least one offset matches
//   k          lowest matching offset (0 when hit is low)
module csi_rx_sync_match
  import csi_rx_pkg::*;
(
  input  logic [15:0] w,
  input  logic [7:0]  sync_byte,
  output logic        hit,
  output logic [2:0]  k
);

  // Scan from the highest offset down so that a lower matching offset
  // overwrites a higher one: the earliest position on the wire wins.
  always_comb begin
    hit = 1'b0;
    k   = 3'd0;
    for (int i = SYNC_OFFSETS - 1; i >= 0; i--) begin
      if (w[i +: 8] == sync_byte) begin
        hit = 1'b1;
        k   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/csi_rx_byte_align.sv
// rtl/csi_rx_byte_align.sv - SoT byte aligner for one CSI-2 D-PHY data lane
//
// Purpose: hunts the first bytes of each HS burst for SYNC_BYTE at any of 8
// bit offsets, locks onto the lowest matching offset and streams byte-aligned
// payload until the burst ends.
// Ports:
//   CLK           byte clock, lane PHY DOUT_CLK domain
//   RST_N         asynchronous active-low reset
//   DIN_VALID     raw byte valid, high for the whole HS burst
//   DIN[7:0]      raw deserialized byte, DIN[0] earliest on the wire
//   DOUT_VALID    aligned byte valid
//   DOUT[7:0]     aligned payload byte (the sync byte is not forwarded)
//   DOUT_SOT      marks the first aligned byte of a burst
//   ALIGN_OFFSET  offset of the most recent lock, held until the next lock
//   SYNC_ERR      one-cycle pulse when the hunt gives up
module csi_rx_byte_align
  import csi_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned SEARCH_LIMIT = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN_VALID,
  input  logic [7:0] DIN,
  output logic       DOUT_VALID,
  output logic [7:0] DOUT,
  output logic       DOUT_SOT,
  output logic [2:0] ALIGN_OFFSET,
  output logic       SYNC_ERR
);

  // Counter value on which one more failed evaluation exhausts the hunt.
  localparam logic [7:0] LAST_COUNT = 8'(SEARCH_LIMIT - 1);

  align_state_e state;
  align_state_e state_next;
  logic [7:0]   prev;
  logic         prev_ok;
  logic [7:0]   search_cnt;
  logic         sot_pending;

  logic [15:0]  window;
  logic         hit;
  logic [2:0]   hit_k;

  logic         hunt_eval;
  logic         lock_now;
  logic         give_up;
  logic         emit;

  // Current byte on top, previous one below: window[0] is the oldest bit.
  assign window = {DIN, prev};

  csi_rx_sync_match u_sync_match (
    .w         (window),
    .sync_byte (SYNC_BYTE),
    .hit       (hit),
    .k         (hit_k)
  );

  // A window is only meaningful once the previous byte belongs to this burst.
  // A lock takes priority over the timeout on the same evaluation.
  always_comb begin
    hunt_eval = DIN_VALID && prev_ok && (state == ST_HUNT);
    lock_now  = hunt_eval && hit;
    give_up   = hunt_eval && !hit && (search_cnt == LAST_COUNT);
    emit      = DIN_VALID && (state == ST_LOCKED);
  end

  always_comb begin
    state_next = state;
    if (!DIN_VALID) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_HUNT;
        ST_HUNT: begin
          if (lock_now) begin
            state_next = ST_LOCKED;
          end else if (give_up) begin
            state_next = ST_ERROR;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      prev    <= 8'h00;
      prev_ok <= 1'b0;
    end else begin
      state   <= state_next;
      prev_ok <= DIN_VALID;
      if (DIN_VALID) begin
        prev <= DIN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      search_cnt <= 8'h00;
    end else if (!DIN_VALID || lock_now || give_up) begin
      search_cnt <= 8'h00;
    end else if (hunt_eval) begin
      search_cnt <= search_cnt + 8'h01;
    end
  end

  // sot_pending tags the first aligned byte after a lock; a gap drops it so a
  // burst that ends on its match cycle leaves nothing behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALIGN_OFFSET <= 3'd0;
      sot_pending  <= 1'b0;
    end else begin
      if (lock_now) begin
        ALIGN_OFFSET <= hit_k;
      end
      if (!DIN_VALID) begin
        sot_pending <= 1'b0;
      end else if (lock_now) begin
        sot_pending <= 1'b1;
      end else if (emit) begin
        sot_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT_VALID <= 1'b0;
      DOUT       <= 8'h00;
      DOUT_SOT   <= 1'b0;
      SYNC_ERR   <= 1'b0;
    end else begin
      DOUT_VALID <= emit;
      DOUT_SOT   <= emit && sot_pending;
      SYNC_ERR   <= give_up;
      if (emit) begin
        DOUT <= window_byte(window, ALIGN_OFFSET);
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_byte_align.sv
// tb/tb_csi_rx_byte_align.sv - self-checking bench for csi_rx_byte_align
module tb_csi_rx_byte_align;

  localparam logic [7:0] SYNC  = 8'hB8;
  localparam int         LIMIT = 16;
  localparam int         MAXB  = 40;
  localparam int         NS    = MAXB + 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DOUT_VALID;
  logic [7:0] DOUT;
  logic       DOUT_SOT;
  logic [2:0] ALIGN_OFFSET;
  logic       SYNC_ERR;

  logic [15:0] sm_w = 16'h0000;
  logic [7:0]  sm_sync = 8'h00;
  logic        sm_hit;
  logic [2:0]  sm_k;

  csi_rx_byte_align dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .DIN_VALID    (DIN_VALID),
    .DIN          (DIN),
    .DOUT_VALID   (DOUT_VALID),
    .DOUT         (DOUT),
    .DOUT_SOT     (DOUT_SOT),
    .ALIGN_OFFSET (ALIGN_OFFSET),
    .SYNC_ERR     (SYNC_ERR)
  );

  csi_rx_sync_match u_sm (
    .w         (sm_w),
    .sync_byte (sm_sync),
    .hit       (sm_hit),
    .k         (sm_k)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]          burst [MAXB];
  int                  blen = 0;
  logic [8*MAXB-1:0]   gen;
  logic                exp_v [NS];
  logic [7:0]          exp_d [NS];
  logic                exp_s [NS];
  logic                exp_e [NS];
  logic [2:0]          exp_a [NS];
  logic [2:0]          align_model = 3'd0;
  logic [7:0]          first_dout;
  int                  err_seen;
  int                  out_seen;

  // Reference: treat the burst as one bit stream, find the first occurrence
  // of the sync pattern, and derive lock cycle, offset and payload from it.
  task automatic build_expect();
    logic [8*MAXB-1:0] bits;
    int p_hit;
    int lock_i;
    logic [2:0] k;
    bits = '0;
    p_hit = -1;
    for (int i = 0; i < blen; i++) bits[8*i +: 8] = burst[i];
    for (int s = 0; s < NS; s++) begin
      exp_v[s] = 1'b0; exp_d[s] = 8'h00; exp_s[s] = 1'b0;
      exp_e[s] = 1'b0; exp_a[s] = align_model;
    end
    for (int p = 0; p <= 8*blen - 8; p++)
      if (p_hit < 0 && bits[p +: 8] == SYNC) p_hit = p;
    lock_i = (p_hit >= 0) ? (p_hit / 8 + 1) : MAXB + 10;
    if (lock_i <= blen - 1 && lock_i <= LIMIT) begin
      k = 3'(p_hit % 8);
      for (int s = lock_i + 1; s < NS; s++) exp_a[s] = k;
      align_model = k;
      for (int j = lock_i + 1; j < blen; j++) begin
        exp_v[j+1] = 1'b1;
        exp_d[j+1] = bits[p_hit + 8 + 8*(j - lock_i - 1) +: 8];
        exp_s[j+1] = (j == lock_i + 1);
      end
    end else if (blen - 1 >= LIMIT) begin
      exp_e[LIMIT+1] = 1'b1;
    end
  endtask

  // Drives burst[0..blen-1] followed by a gap; sample s reflects input s-1.
  task automatic run_burst(input string name);
    build_expect();
    err_seen = 0;
    out_seen = 0;
    first_dout = 8'hFF;
    for (int s = 0; s < blen + 3; s++) begin
      @(negedge CLK);
      checks++;
      if (DOUT_VALID !== exp_v[s]) begin
        errors++;
        $display("FAIL %s dout_valid s=%0d got %b want %b", name, s, DOUT_VALID, exp_v[s]);
      end
      checks++;
      if (DOUT_SOT !== exp_s[s]) begin
        errors++;
        $display("FAIL %s dout_sot s=%0d got %b want %b", name, s, DOUT_SOT, exp_s[s]);
      end
      checks++;
      if (SYNC_ERR !== exp_e[s]) begin
        errors++;
        $display("FAIL %s sync_err s=%0d got %b want %b", name, s, SYNC_ERR, exp_e[s]);
      end
      checks++;
      if (ALIGN_OFFSET !== exp_a[s]) begin
        errors++;
        $display("FAIL %s align_offset s=%0d got %0d want %0d", name, s, ALIGN_OFFSET, exp_a[s]);
      end
      if (exp_v[s]) begin
        checks++;
        if (DOUT !== exp_d[s]) begin
          errors++;
          $display("FAIL %s dout s=%0d got %h want %h", name, s, DOUT, exp_d[s]);
        end
      end
      if (SYNC_ERR === 1'b1) err_seen++;
      if (DOUT_VALID === 1'b1) out_seen++;
      if (DOUT_VALID === 1'b1 && DOUT_SOT === 1'b1) first_dout = DOUT;
      if (s < blen) begin
        DIN_VALID = 1'b1;
        DIN = burst[s];
      end else begin
        DIN_VALID = 1'b0;
        DIN = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    DIN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (DOUT_VALID !== 1'b0) begin errors++; $display("FAIL reset dout_valid got %b want 0", DOUT_VALID); end
    checks++; if (DOUT !== 8'h00) begin errors++; $display("FAIL reset dout got %h want 00", DOUT); end
    checks++; if (DOUT_SOT !== 1'b0) begin errors++; $display("FAIL reset dout_sot got %b want 0", DOUT_SOT); end
    checks++; if (ALIGN_OFFSET !== 3'd0) begin errors++; $display("FAIL reset align got %0d want 0", ALIGN_OFFSET); end
    checks++; if (SYNC_ERR !== 1'b0) begin errors++; $display("FAIL reset sync_err got %b want 0", SYNC_ERR); end
    RST_N = 1'b1;
    align_model = 3'd0;
  endtask

  task automatic test_offset0();
    burst[0] = 8'h00; burst[1] = 8'hB8; burst[2] = 8'h12; burst[3] = 8'h34; burst[4] = 8'h56;
    blen = 5;
    run_burst("offset0");
    checks++; if (first_dout !== 8'h12) begin errors++; $display("FAIL offset0 first_dout got %h want 12", first_dout); end
    checks++; if (out_seen !== 2) begin errors++; $display("FAIL offset0 out_count got %0d want 2", out_seen); end
    checks++; if (ALIGN_OFFSET !== 3'd0) begin errors++; $display("FAIL offset0 align got %0d want 0", ALIGN_OFFSET); end
  endtask

  task automatic test_offset3();
    burst[0] = 8'h00; burst[1] = 8'hC0; burst[2] = 8'h2D; burst[3] = 8'h05; burst[4] = 8'h00;
    blen = 5;
    run_burst("offset3");
    checks++; if (first_dout !== 8'hA5) begin errors++; $display("FAIL offset3 first_dout got %h want a5", first_dout); end
    checks++; if (ALIGN_OFFSET !== 3'd3) begin errors++; $display("FAIL offset3 align got %0d want 3", ALIGN_OFFSET); end
  endtask

  task automatic test_gap_on_match();
    burst[0] = 8'h00; burst[1] = 8'hB8; burst[2] = 8'h12;
    blen = 3;
    run_burst("gap_on_match");
    checks++; if (out_seen !== 0) begin errors++; $display("FAIL gap_on_match out_count got %0d want 0", out_seen); end
    checks++; if (ALIGN_OFFSET !== 3'd0) begin errors++; $display("FAIL gap_on_match align got %0d want 0", ALIGN_OFFSET); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 20; i++) burst[i] = 8'h00;
    blen = 20;
    run_burst("timeout");
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL timeout err_pulses got %0d want 1", err_seen); end
    checks++; if (out_seen !== 0) begin errors++; $display("FAIL timeout out_count got %0d want 0", out_seen); end
    burst[0] = 8'h00; burst[1] = 8'hB8; burst[2] = 8'h12; burst[3] = 8'h34; burst[4] = 8'h56;
    blen = 5;
    run_burst("timeout_recover");
    checks++; if (out_seen !== 2) begin errors++; $display("FAIL timeout_recover out_count got %0d want 2", out_seen); end
  endtask

  task automatic test_burst_end();
    gen = '0;
    gen[13 +: 8] = SYNC;
    for (int b = 0; b < 8; b++) gen[21 + 8*b +: 8] = 8'($urandom);
    blen = 7;
    for (int i = 0; i < blen; i++) burst[i] = gen[8*i +: 8];
    run_burst("burst_end");
    checks++; if (ALIGN_OFFSET !== 3'd5) begin errors++; $display("FAIL burst_end align got %0d want 5", ALIGN_OFFSET); end
    checks++; if (out_seen !== 4) begin errors++; $display("FAIL burst_end out_count got %0d want 4", out_seen); end
  endtask

  task automatic test_lock_at_limit();
    for (int i = 0; i < 15; i++) burst[i] = 8'h00;
    burst[15] = SYNC;
    for (int i = 16; i < 20; i++) burst[i] = 8'($urandom);
    blen = 20;
    run_burst("lock_at_limit");
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL lock_at_limit err_pulses got %0d want 0", err_seen); end
    checks++; if (out_seen !== 3) begin errors++; $display("FAIL lock_at_limit out_count got %0d want 3", out_seen); end
    checks++; if (ALIGN_OFFSET !== 3'd0) begin errors++; $display("FAIL lock_at_limit align got %0d want 0", ALIGN_OFFSET); end
  endtask

  task automatic test_limit_overrun();
    for (int i = 0; i < 16; i++) burst[i] = 8'h00;
    burst[16] = SYNC;
    for (int i = 17; i < 20; i++) burst[i] = 8'($urandom);
    blen = 20;
    run_burst("limit_overrun");
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL limit_overrun err_pulses got %0d want 1", err_seen); end
    checks++; if (out_seen !== 0) begin errors++; $display("FAIL limit_overrun out_count got %0d want 0", out_seen); end
  endtask

  task automatic test_multi_candidate();
    logic       e_hit;
    logic [2:0] e_k;
    int         r;
    sm_w = 16'hCCCC; sm_sync = 8'h33;
    #1;
    checks++; if (sm_hit !== 1'b1 || sm_k !== 3'd2) begin
      errors++; $display("FAIL multi_candidate got hit=%b k=%0d want hit=1 k=2", sm_hit, sm_k);
    end
    sm_w = 16'h0000; sm_sync = SYNC;
    #1;
    checks++; if (sm_hit !== 1'b0) begin errors++; $display("FAIL multi_none hit got %b want 0", sm_hit); end
    for (int n = 0; n < 100; n++) begin
      sm_w = 16'($urandom);
      r = $urandom_range(0, 7);
      sm_sync = ($urandom_range(0, 3) != 0) ? sm_w[r +: 8] : 8'($urandom);
      #1;
      e_hit = 1'b0; e_k = 3'd0;
      for (int k = 0; k < 8; k++)
        if (!e_hit && sm_w[k +: 8] == sm_sync) begin e_hit = 1'b1; e_k = 3'(k); end
      checks++;
      if (sm_hit !== e_hit || (e_hit && sm_k !== e_k)) begin
        errors++;
        $display("FAIL match_rand w=%h sync=%h got %b/%0d want %b/%0d", sm_w, sm_sync, sm_hit, sm_k, e_hit, e_k);
      end
    end
  endtask

  task automatic test_random();
    int p0;
    for (int n = 0; n < 40; n++) begin
      blen = $urandom_range(2, 36);
      for (int i = 0; i < MAXB/4; i++) gen[32*i +: 32] = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        p0 = $urandom_range(0, 8*blen - 9);
        gen[p0 +: 8] = SYNC;
      end
      for (int i = 0; i < blen; i++) burst[i] = gen[8*i +: 8];
      run_burst("random");
    end
  endtask

  task automatic test_reset_locked();
    burst[0] = 8'h00; burst[1] = 8'hB8; burst[2] = 8'h12;
    burst[3] = 8'h34; burst[4] = 8'h56; burst[5] = 8'h78;
    for (int s = 0; s < 6; s++) begin
      @(negedge CLK);
      DIN_VALID = 1'b1;
      DIN = burst[s];
    end
    @(posedge CLK);
    #2;
    checks++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'h56) begin
      errors++; $display("FAIL reset_locked streaming got %b/%h want 1/56", DOUT_VALID, DOUT);
    end
    RST_N = 1'b0;
    #1;
    checks++; if (DOUT_VALID !== 1'b0 || DOUT !== 8'h00 || DOUT_SOT !== 1'b0 ||
                  ALIGN_OFFSET !== 3'd0 || SYNC_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked async got v=%b d=%h s=%b a=%0d e=%b want all 0",
               DOUT_VALID, DOUT, DOUT_SOT, ALIGN_OFFSET, SYNC_ERR);
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    align_model = 3'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checks++;
      if (DOUT_VALID !== 1'b0 || SYNC_ERR !== 1'b0) begin
        errors++; $display("FAIL reset_idle c=%0d got v=%b e=%b want 0/0", c, DOUT_VALID, SYNC_ERR);
      end
    end
    burst[0] = 8'h00; burst[1] = 8'hC0; burst[2] = 8'h2D; burst[3] = 8'h05; burst[4] = 8'h00;
    blen = 5;
    run_burst("reset_recover");
    checks++; if (first_dout !== 8'hA5) begin errors++; $display("FAIL reset_recover first_dout got %h want a5", first_dout); end
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_offset3();
    test_gap_on_match();
    test_timeout();
    test_burst_end();
    test_lock_at_limit();
    test_limit_overrun();
    test_multi_candidate();
    test_random();
    test_reset_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
